inc_counter: RTL and testbench
==============================

INC_COUNTER -- requirements
Module: inc_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3: count and data width in bits, minimum 1.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port clear, input, 1 bit: synchronous clear request.
REQ-005 SHALL have port load_valid, input, 1 bit: load request.
REQ-006 SHALL have port load_data, input, WIDTH bits: load value.
REQ-007 SHALL have port load_ready, output, 1 bit: load can be accepted.
REQ-008 SHALL have port inc_en, input, 1 bit: request increment after the current beat.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_data, output, WIDTH bits: current count.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port wrap, output, 1 bit: one-cycle pulse when the count wraps or saturates.

Function
REQ-013 SHALL implement FSM states IDLE (out_valid=0), RUN (out_valid=1) and DONE (out_valid=0, reached only with saturation).
REQ-014 SHALL define a transfer as out_valid && out_ready on a rising clk edge.
REQ-015 SHALL drive load_ready = 1 in IDLE and DONE; in RUN, load_ready SHALL equal out_ready.
REQ-016 SHALL apply per-edge priority: clear, then load (load_valid && load_ready), then increment, then hold.
REQ-017 SHALL, on clear from any state, set count to 0 and state to IDLE, discarding any pending beat.
REQ-018 SHALL, on an accepted load, set count to load_data and state to RUN, so out_valid=1 in the next cycle (latency 1).
REQ-019 SHALL, in IDLE with inc_en=1 and no load, move to RUN with the count unchanged.
REQ-020 SHALL, on a RUN transfer with inc_en=1, set count to count+1 (mod 2^WIDTH) and stay in RUN.
REQ-021 SHALL, on a RUN transfer with inc_en=0, keep the count and move to IDLE.
REQ-022 SHALL, in RUN with out_ready=0, hold count and out_data stable regardless of inc_en.
REQ-023 SHALL pulse wrap for exactly one cycle after the transfer that increments from all-ones.
REQ-024 SHALL form count+1 only inside the incrementer sub-module; no other adder is permitted.

Reset
REQ-025 SHALL, on rst_n low, immediately force count=0, state=IDLE, out_valid=0, out_data=0, wrap=0 and load_ready=1.
REQ-026 SHALL abandon any in-flight beat when reset is asserted mid-operation, and SHALL NOT emit a beat until a new load or inc_en is seen after rst_n deasserts.

Configuration
REQ-027 SHALL compile saturation in when macro INC_COUNTER_SATURATE_EN is defined.
REQ-028 SHALL, with the macro defined, on a transfer at all-ones with inc_en=1, keep the count at all-ones, enter DONE and pulse wrap.
REQ-029 SHALL, with the macro defined, leave DONE only by clear or load.
REQ-030 SHALL, without the macro, wrap the count to 0 and never enter DONE.

Structure
REQ-031 SHALL place the state encoding (IDLE, RUN, DONE) and the WIDTH default in shared package inc_pkg.
REQ-032 SHALL instantiate one sub-module, incrementer, for the +1 datapath.

Verification
REQ-033 SHALL cover reset: assert rst_n=0 mid-RUN -> out_valid=0, out_data=0 immediately; no beat until a new load.
REQ-034 SHALL cover load and count: load 3'd5, inc_en=1, out_ready=1 -> beats 5, 6, 7, 0 with wrap pulsed after the 7->0 transfer.
REQ-035 SHALL cover backpressure: load 3'd2, out_ready=0 for 4 cycles -> out_data stays 2; then out_ready=1 -> next beat 3.
REQ-036 SHALL cover simultaneous events: clear and load_valid in the same cycle -> count 0, IDLE, load ignored.
REQ-037 SHALL cover saturation, built with INC_COUNTER_SATURATE_EN: load 3'd6, inc_en=1 -> beats 6, 7, then DONE with wrap pulsed once; load 3'd1 -> RUN with 1.
REQ-038 SHALL cover the stop condition: inc_en=0 on a transfer of 3'd4 -> IDLE with count 4; a later inc_en -> beat 4 again.

Source files
------------

// File: rtl/inc_pkg.sv
// -----------------------------------------------------------------------------
// inc_pkg -- shared definitions for the inc_counter block.
//
// Contents:
//   INC_WIDTH_DEFAULT : default count/data width in bits
//   STATE_W           : width of the FSM state encoding
//   IDLE / RUN / DONE : FSM state encodings (DONE is only reachable when the
//                       block is built with INC_COUNTER_SATURATE_EN)
// -----------------------------------------------------------------------------
package inc_pkg;

    localparam int INC_WIDTH_DEFAULT = 3;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] RUN  = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

endpackage : inc_pkg

// File: rtl/incrementer.sv
// -----------------------------------------------------------------------------
// incrementer -- purely combinational +1 datapath for inc_counter.
//
// Builds the increment as a half-adder ripple chain, so the only "+1" in the
// block lives here.
//
// Ports:
//   in_val  [WIDTH-1:0] in  : value to increment
//   out_val [WIDTH-1:0] out : in_val + 1, modulo 2^WIDTH
//   carry               out : 1 when in_val is all-ones (the increment wraps)
// -----------------------------------------------------------------------------
module incrementer #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] in_val,
    output logic [WIDTH-1:0] out_val,
    output logic             carry
);

    // c[i] is the carry into bit i; injecting 1 at bit 0 gives the +1.
    logic [WIDTH:0] c;

    assign c[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_half_add
            assign out_val[gi] = in_val[gi] ^ c[gi];
            assign c[gi+1]     = in_val[gi] & c[gi];
        end
    endgenerate

    // Carry out of the top bit means every input bit was set.
    assign carry = c[WIDTH];

endmodule : incrementer

// File: rtl/inc_counter.sv
// -----------------------------------------------------------------------------
// inc_counter -- loadable counter that presents its count as a valid/ready
// stream and optionally steps by one after every accepted beat.
//
// Configuration macro:
//   INC_COUNTER_SATURATE_EN : when defined, incrementing past all-ones holds
//                             the count and parks the FSM in DONE (left only
//                             by clear or load). When undefined the count
//                             wraps to 0 and DONE is never entered.
//
// Ports:
//   clk         in  : clock, rising edge
//   rst_n       in  : asynchronous active-low reset
//   clear       in  : synchronous clear (highest priority)
//   load_valid  in  : load request
//   load_data   in  : value to load [WIDTH-1:0]
//   load_ready  out : load can be accepted (1 in IDLE/DONE, out_ready in RUN)
//   inc_en      in  : step the count after the current beat
//   out_valid   out : out_data holds a beat (state RUN)
//   out_data    out : current count [WIDTH-1:0]
//   out_ready   in  : downstream accepts the beat
//   wrap        out : one-cycle pulse after an increment from all-ones
// -----------------------------------------------------------------------------
module inc_counter
    import inc_pkg::*;
#(
    parameter int WIDTH = INC_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             inc_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             wrap
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               wrap_q,  wrap_d;

    logic [WIDTH-1:0]   count_inc;
    logic               count_at_max;
    logic               transfer;
    logic               load_accept;

    incrementer #(
        .WIDTH (WIDTH)
    ) u_incrementer (
        .in_val  (count_q),
        .out_val (count_inc),
        .carry   (count_at_max)
    );

    assign out_valid   = (state_q == RUN);
    assign out_data    = count_q;
    assign wrap        = wrap_q;
    // While a beat is pending a load may only replace it once it is taken.
    assign load_ready  = (state_q != RUN) || out_ready;
    assign transfer    = out_valid && out_ready;
    assign load_accept = load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_accept) begin
            state_d = RUN;
            count_d = load_data;
        end else begin
            case (state_q)
                IDLE: begin
                    if (inc_en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (transfer) begin
                        if (inc_en) begin
                            wrap_d = count_at_max;
`ifdef INC_COUNTER_SATURATE_EN
                            if (count_at_max) begin
                                state_d = DONE;
                            end else begin
                                count_d = count_inc;
                            end
`else
                            count_d = count_inc;
`endif
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DONE: begin
                    // Parked until clear or load, both handled above.
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule : inc_counter

// File: tb/tb_inc_counter.sv
// -----------------------------------------------------------------------------
// tb_inc_counter -- directed-vector self-checking bench for inc_counter
// (WIDTH = 3). Inputs change and outputs are sampled 1 time unit after each
// rising clock edge. The saturation scenario is compiled in only when
// INC_COUNTER_SATURATE_EN is defined; otherwise the wrap scenario covers the
// default build.
// -----------------------------------------------------------------------------
module tb_inc_counter;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         load_valid;
    logic [W-1:0] load_data;
    logic         load_ready;
    logic         inc_en;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         wrap;

    int n_vec;
    int n_err;

    inc_counter #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .inc_en     (inc_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .wrap       (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", tag, got, $time);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the beat-side outputs in one call.
    task automatic check_beat(input string tag, input logic v, input logic [W-1:0] d, input logic w);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".wrap"},  32'(wrap),      32'(w));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        inc_en     = 1'b0;
        out_ready  = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check_beat("rst", 1'b0, 3'd0, 1'b0);
        check("rst.load_ready", 32'(load_ready), 32'd1);
        step();
        step();
        rst_n = 1'b1;

        // ---------------- load 5 and count with wrap ----------------
        load_valid = 1'b1; load_data = 3'd5; inc_en = 1'b1; out_ready = 1'b1;
        step();
        load_valid = 1'b0;
        check_beat("cnt.b5", 1'b1, 3'd5, 1'b0);
        step();
        check_beat("cnt.b6", 1'b1, 3'd6, 1'b0);
        step();
        check_beat("cnt.b7", 1'b1, 3'd7, 1'b0);
        step();
`ifndef INC_COUNTER_SATURATE_EN
        check_beat("cnt.b0_wrap", 1'b1, 3'd0, 1'b1);
        step();
        check_beat("cnt.b1", 1'b1, 3'd1, 1'b0);
`endif
        out_ready = 1'b0;

        // ---------------- backpressure ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_beat("clr", 1'b0, 3'd0, 1'b0);
        load_valid = 1'b1; load_data = 3'd2; inc_en = 1'b1; out_ready = 1'b0;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("bp.hold%0d", i), 1'b1, 3'd2, 1'b0);
            check($sformatf("bp.load_ready%0d", i), 32'(load_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        check_beat("bp.b3", 1'b1, 3'd3, 1'b0);

        // ---------------- stop condition ----------------
        load_valid = 1'b1; load_data = 3'd4;
        step();
        load_valid = 1'b0; inc_en = 1'b0;
        check_beat("stop.b4", 1'b1, 3'd4, 1'b0);
        step();
        check_beat("stop.idle", 1'b0, 3'd4, 1'b0);
        step();
        check_beat("stop.idle2", 1'b0, 3'd4, 1'b0);
        inc_en = 1'b1;
        step();
        check_beat("stop.again", 1'b1, 3'd4, 1'b0);
        inc_en = 1'b0; out_ready = 1'b0;

        // ---------------- clear and load together ----------------
        clear = 1'b1; load_valid = 1'b1; load_data = 3'd6;
        step();
        clear = 1'b0; load_valid = 1'b0;
        check_beat("clrld", 1'b0, 3'd0, 1'b0);
        step();
        check_beat("clrld.stay", 1'b0, 3'd0, 1'b0);

        // ---------------- reset mid-RUN ----------------
        load_valid = 1'b1; load_data = 3'd5; inc_en = 1'b1;
        step();
        load_valid = 1'b0;
        check_beat("mid.run", 1'b1, 3'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_beat("mid.rst", 1'b0, 3'd0, 1'b0);
        check("mid.load_ready", 32'(load_ready), 32'd1);
        inc_en = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        check_beat("mid.quiet1", 1'b0, 3'd0, 1'b0);
        step();
        check_beat("mid.quiet2", 1'b0, 3'd0, 1'b0);
        load_valid = 1'b1; load_data = 3'd1;
        step();
        load_valid = 1'b0;
        check_beat("mid.reload", 1'b1, 3'd1, 1'b0);
        step();
        check_beat("mid.done", 1'b0, 3'd1, 1'b0);

`ifdef INC_COUNTER_SATURATE_EN
        // ---------------- saturation ----------------
        clear = 1'b1;
        step();
        clear = 1'b0;
        load_valid = 1'b1; load_data = 3'd6; inc_en = 1'b1; out_ready = 1'b1;
        step();
        load_valid = 1'b0;
        check_beat("sat.b6", 1'b1, 3'd6, 1'b0);
        step();
        check_beat("sat.b7", 1'b1, 3'd7, 1'b0);
        step();
        check_beat("sat.done", 1'b0, 3'd7, 1'b1);
        check("sat.load_ready", 32'(load_ready), 32'd1);
        step();
        check_beat("sat.park", 1'b0, 3'd7, 1'b0);
        step();
        check_beat("sat.park2", 1'b0, 3'd7, 1'b0);
        load_valid = 1'b1; load_data = 3'd1;
        step();
        load_valid = 1'b0;
        check_beat("sat.reload", 1'b1, 3'd1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_inc_counter
